// File: rtl/video_in_pkg.sv
// Shared types and constants for the video input DMA block.
package video_in_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_PACK = 2'd1,
      WRITE     = 2'd2,
      IRQ       = 2'd3
   } state_t;

   localparam int DEF_WIDTH     = 640;
   localparam int DEF_HEIGHT    = 480;
   localparam int DEF_PACK      = 16;
   localparam int P_IRQ_CYC_MIN = 3;

endpackage

// File: rtl/video_in_irq_pulse.sv
// Frame-done interrupt stretcher: a one-cycle start yields irq for P_LEN cycles.
module video_in_irq_pulse #(
   parameter int P_LEN = 3
) (
   input  logic clk,
   input  logic nRST,
   input  logic start,
   output logic irq,
   output logic last
);
   localparam int CW = $clog2(P_LEN + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Load on start, then count down to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (start)
         cnt_d = CW'(P_LEN);
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   // Countdown register.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign irq  = (cnt_q != '0);
   assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/video_in_dma.sv
// Video input DMA: drains a FIFO into memory over Wishbone, one frame per base
// address, and raises a stretched irq at frame end.
// Optional: define VIDEO_IN_DMA_ERR_RETRY_EN to retry an ERR'd beat up to 3 times
// before aborting; otherwise the first ERR aborts the frame.
module video_in_dma
   import video_in_pkg::*;
#(
   parameter int P_WIDTH   = DEF_WIDTH,
   parameter int P_HEIGHT  = DEF_HEIGHT,
   parameter int P_PACK    = DEF_PACK,
   parameter int P_IRQ_CYC = 3
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        addr_valid,
   input  logic [31:0] addr_data,
   input  logic        pack_avail,
   input  logic [31:0] fifo_data,
   output logic        fifo_re,
   output logic        irq,
   output logic        frame_err,
   output logic        wb_CYC_O,
   output logic        wb_STB_O,
   output logic        wb_WE_O,
   output logic [3:0]  wb_SEL_O,
   output logic [31:0] wb_ADR_O,
   output logic [31:0] wb_DAT_O,
   input  logic        wb_ACK_I,
   input  logic        wb_ERR_I
);
   localparam int TOTAL   = P_WIDTH * P_HEIGHT / 4;
   localparam int WC_W    = $clog2(TOTAL) + 1;
   localparam int BC_W    = $clog2(P_PACK) + 1;
   localparam int IRQ_LEN = (P_IRQ_CYC < P_IRQ_CYC_MIN) ? P_IRQ_CYC_MIN : P_IRQ_CYC;

   state_t            state_q, state_d;
   logic [31:0]       base_q, base_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic              pend_q, pend_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic              frame_err_q, frame_err_d;
   logic              gap_q, gap_d;      // STB held low for one cycle before a retry
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
   logic [1:0]        retry_cnt_q, retry_cnt_d;
`endif
   logic              abort;
   logic              irq_start;
   logic              irq_last;
   logic              in_write;

   assign in_write = (state_q == WRITE);

   // Next-state, counters, pending address and FIFO pop.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      pend_addr_d = pend_addr_q;
      pend_d      = pend_q;
      word_cnt_d  = word_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      frame_err_d = 1'b0;
      gap_d       = gap_q;
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
      retry_cnt_d = retry_cnt_q;
`endif
      abort       = 1'b0;
      irq_start   = 1'b0;
      fifo_re     = 1'b0;

      // Addresses arriving while busy (including the last irq cycle) queue up.
      if (addr_valid && state_q != IDLE) begin
         pend_d      = 1'b1;
         pend_addr_d = addr_data;
      end

      case (state_q)
         IDLE: begin
            if (addr_valid) begin
               base_d     = addr_data;
               word_cnt_d = '0;
               pend_d     = 1'b0;
               state_d    = WAIT_PACK;
            end else if (pend_q) begin
               base_d     = pend_addr_q;
               word_cnt_d = '0;
               pend_d     = 1'b0;
               state_d    = WAIT_PACK;
            end
         end
         WAIT_PACK: begin
            if (pack_avail) begin
               beat_cnt_d = BC_W'(P_PACK);
               gap_d      = 1'b0;
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
               retry_cnt_d = 2'd0;
`endif
               state_d    = WRITE;
            end
         end
         WRITE: begin
            if (gap_q) begin
               gap_d = 1'b0;
            end else if (wb_ERR_I) begin
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
               if (retry_cnt_q != 2'd3) begin
                  retry_cnt_d = retry_cnt_q + 2'd1;
                  gap_d       = 1'b1;
               end else begin
                  abort = 1'b1;
               end
`else
               abort = 1'b1;
`endif
            end else if (wb_ACK_I) begin
               fifo_re    = 1'b1;
               word_cnt_d = word_cnt_q + WC_W'(1);
               beat_cnt_d = beat_cnt_q - BC_W'(1);
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
               retry_cnt_d = 2'd0;
`endif
               if (beat_cnt_q == BC_W'(1)) begin
                  if (word_cnt_q == WC_W'(TOTAL - 1)) begin
                     state_d   = IRQ;
                     irq_start = 1'b1;
                  end else begin
                     state_d = WAIT_PACK;
                  end
               end
            end
         end
         IRQ: begin
            if (irq_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Bus error abort: leave the frame and whatever remains in the FIFO.
      if (abort) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
         gap_d       = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         base_q      <= '0;
         pend_addr_q <= '0;
         pend_q      <= 1'b0;
         word_cnt_q  <= '0;
         beat_cnt_q  <= '0;
         frame_err_q <= 1'b0;
         gap_q       <= 1'b0;
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
         retry_cnt_q <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         pend_addr_q <= pend_addr_d;
         pend_q      <= pend_d;
         word_cnt_q  <= word_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_err_q <= frame_err_d;
         gap_q       <= gap_d;
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
         retry_cnt_q <= retry_cnt_d;
`endif
      end
   end

   video_in_irq_pulse #(.P_LEN(IRQ_LEN)) u_irq (
      .clk   (clk),
      .nRST  (nRST),
      .start (irq_start),
      .irq   (irq),
      .last  (irq_last)
   );

   // Bus outputs are decoded from registered state so reset clears them at once.
   assign wb_CYC_O  = in_write;
   assign wb_STB_O  = in_write & ~gap_q;
   assign wb_WE_O   = in_write;
   assign wb_SEL_O  = 4'hF;
   assign wb_ADR_O  = in_write ? base_q + (32'(word_cnt_q) << 2) : 32'h0;
   assign wb_DAT_O  = in_write ? fifo_data : 32'h0;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_video_in_dma.sv
// Directed bench for video_in_dma: 8x2 frame (4 words), 2-word packets.
module tb_video_in_dma;
   logic        clk = 1'b0;
   logic        nRST;
   logic        addr_valid;
   logic [31:0] addr_data;
   logic        pack_avail;
   logic [31:0] fifo_data;
   logic        fifo_re, irq, frame_err;
   logic        wb_CYC_O, wb_STB_O, wb_WE_O;
   logic [3:0]  wb_SEL_O;
   logic [31:0] wb_ADR_O, wb_DAT_O;
   logic        wb_ACK_I, wb_ERR_I;

   video_in_dma #(.P_WIDTH(8), .P_HEIGHT(2), .P_PACK(2), .P_IRQ_CYC(3)) dut (
      .clk(clk), .nRST(nRST), .addr_valid(addr_valid), .addr_data(addr_data),
      .pack_avail(pack_avail), .fifo_data(fifo_data), .fifo_re(fifo_re),
      .irq(irq), .frame_err(frame_err), .wb_CYC_O(wb_CYC_O), .wb_STB_O(wb_STB_O),
      .wb_WE_O(wb_WE_O), .wb_SEL_O(wb_SEL_O), .wb_ADR_O(wb_ADR_O),
      .wb_DAT_O(wb_DAT_O), .wb_ACK_I(wb_ACK_I), .wb_ERR_I(wb_ERR_I));

   always #5 clk = ~clk;

   // slave / FIFO model
   bit          ack_en = 1'b1;
   logic [31:0] err_adr = 32'h0;
   int          err_limit = 0, err_base = 0;
   int          err_seen = 0, pop_cnt = 0, irq_hi = 0, irq_fall = 0, ferr_cnt = 0;
   logic        irq_prev = 1'b0;
   logic [31:0] adr_q[$];
   logic [31:0] dat_q[$];

   assign wb_ACK_I  = wb_STB_O & ack_en;
   assign wb_ERR_I  = wb_STB_O && (wb_ADR_O == err_adr) && ((err_seen - err_base) < err_limit);
   assign fifo_data = 32'hD000_0000 + 32'(pop_cnt);

   always @(posedge clk) begin
      if (wb_CYC_O && wb_STB_O && (wb_ACK_I || wb_ERR_I)) begin
         adr_q.push_back(wb_ADR_O);
         dat_q.push_back(wb_DAT_O);
      end
      if (fifo_re)          pop_cnt  <= pop_cnt + 1;
      if (wb_ERR_I)         err_seen <= err_seen + 1;
      if (irq)              irq_hi   <= irq_hi + 1;
      if (irq_prev && !irq) irq_fall <= irq_fall + 1;
      if (frame_err)        ferr_cnt <= ferr_cnt + 1;
      irq_prev <= irq;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [31:0] a);
      @(negedge clk);
      addr_valid = 1'b1;
      addr_data  = a;
      @(negedge clk);
      addr_valid = 1'b0;
   endtask

   task automatic wait_fall(input int target, input string tag);
      for (int i = 0; i < 300 && irq_fall < target; i++) @(negedge clk);
      chk(tag, 32'(irq_fall >= target), 32'd1);
   endtask

   int a0, p0, h0, f0, e0, pm, cyc_gap, n1004;

   initial begin
      nRST = 1'b0; addr_valid = 1'b0; addr_data = 32'h0; pack_avail = 1'b0;
      repeat (3) tick();
      #1;
      chk("rst_cyc", 32'(wb_CYC_O), 0);
      chk("rst_stb", 32'(wb_STB_O), 0);
      chk("rst_we",  32'(wb_WE_O), 0);
      chk("rst_sel", 32'(wb_SEL_O), 32'hF);
      chk("rst_adr", wb_ADR_O, 0);
      chk("rst_dat", wb_DAT_O, 0);
      chk("rst_re",  32'(fifo_re), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      nRST = 1'b1;
      repeat (2) tick();

      // A: basic frame with immediate ACK
      pack_avail = 1'b1;
      a0 = adr_q.size(); p0 = pop_cnt; h0 = irq_hi; f0 = irq_fall;
      start_frame(32'h1000);
      wait_fall(f0 + 1, "A_done");
      repeat (5) tick();
      chk("A_nwr", 32'(adr_q.size() - a0), 4);
      for (int i = 0; i < 4; i++) begin
         chk("A_adr", adr_q[a0+i], 32'h1000 + 32'(4*i));
         chk("A_dat", dat_q[a0+i], 32'hD000_0000 + 32'(p0 + i));
      end
      chk("A_pops", 32'(pop_cnt - p0), 4);
      chk("A_irq_len", 32'(irq_hi - h0), 3);
      chk("A_idle_cyc", 32'(wb_CYC_O), 0);

      // B: FIFO starves for 10 cycles between packets
      a0 = adr_q.size(); f0 = irq_fall;
      start_frame(32'h1000);
      for (int i = 0; i < 100 && adr_q.size() < a0 + 2; i++) tick();
      pack_avail = 1'b0;
      pm = pop_cnt; cyc_gap = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         cyc_gap += int'(wb_CYC_O);
      end
      chk("B_gap_cyc", 32'(cyc_gap), 0);
      chk("B_gap_pops", 32'(pop_cnt - pm), 0);
      pack_avail = 1'b1;
      wait_fall(f0 + 1, "B_done");
      chk("B_nwr", 32'(adr_q.size() - a0), 4);
      chk("B_resume", adr_q[a0+2], 32'h1008);
      chk("B_last", adr_q[a0+3], 32'h100C);

      // C: address offered mid-frame chains the next frame
      a0 = adr_q.size(); f0 = irq_fall;
      start_frame(32'h1000);
      for (int i = 0; i < 100 && adr_q.size() < a0 + 1; i++) tick();
      start_frame(32'h2000);
      wait_fall(f0 + 2, "C_done");
      chk("C_nwr", 32'(adr_q.size() - a0), 8);
      chk("C_f2_first", adr_q[a0+4], 32'h2000);
      chk("C_f2_last", adr_q[a0+7], 32'h200C);

      // C2: address offered in the last irq cycle
      repeat (3) tick();
      a0 = adr_q.size(); f0 = irq_fall;
      start_frame(32'h1000);
      for (int i = 0; i < 100 && !irq; i++) tick();
      repeat (2) tick();
      addr_valid = 1'b1; addr_data = 32'h3000;
      tick();
      addr_valid = 1'b0;
      wait_fall(f0 + 2, "C2_done");
      chk("C2_nwr", 32'(adr_q.size() - a0), 8);
      chk("C2_first", adr_q[a0+4], 32'h3000);
      repeat (3) tick();

      // D: bus error on beat 2 (ACK asserted alongside ERR)
      a0 = adr_q.size(); p0 = pop_cnt; h0 = irq_hi; f0 = irq_fall; e0 = ferr_cnt;
      err_base = err_seen; err_adr = 32'h1004;
`ifdef VIDEO_IN_DMA_ERR_RETRY_EN
      err_limit = 2;
      start_frame(32'h1000);
      wait_fall(f0 + 1, "D_done");
      repeat (3) tick();
      n1004 = 0;
      for (int i = a0; i < adr_q.size(); i++) if (adr_q[i] == 32'h1004) n1004++;
      chk("D_tries", 32'(n1004), 3);
      chk("D_nstrobe", 32'(adr_q.size() - a0), 6);
      chk("D_pops", 32'(pop_cnt - p0), 4);
      chk("D_ferr", 32'(ferr_cnt - e0), 0);
      chk("D_irq", 32'(irq_hi - h0), 3);
      chk("D_dat_retry", dat_q[a0+3], 32'hD000_0000 + 32'(p0 + 1));
`else
      err_limit = 1;
      start_frame(32'h1000);
      for (int i = 0; i < 100 && ferr_cnt == e0; i++) tick();
      repeat (5) tick();
      chk("D_ferr", 32'(ferr_cnt - e0), 1);
      chk("D_pops", 32'(pop_cnt - p0), 1);
      chk("D_nstrobe", 32'(adr_q.size() - a0), 2);
      chk("D_irq", 32'(irq_hi - h0), 0);
      chk("D_idle_cyc", 32'(wb_CYC_O), 0);
`endif
      err_limit = 0;
      repeat (3) tick();

      // E: reset in the middle of a burst
      f0 = irq_fall;
      start_frame(32'h1000);
      for (int i = 0; i < 100 && !wb_STB_O; i++) tick();
      chk("E_pre_re", 32'(fifo_re), 1);
      nRST = 1'b0;
      #1;
      chk("E_cyc", 32'(wb_CYC_O), 0);
      chk("E_stb", 32'(wb_STB_O), 0);
      chk("E_re",  32'(fifo_re), 0);
      repeat (2) tick();
      nRST = 1'b1;
      repeat (6) tick();
      chk("E_idle_cyc", 32'(wb_CYC_O), 0);
      chk("E_noirq", 32'(irq_fall - f0), 0);
      a0 = adr_q.size();
      start_frame(32'h4000);
      wait_fall(f0 + 1, "E_done");
      chk("E_nwr", 32'(adr_q.size() - a0), 4);
      chk("E_first", adr_q[a0], 32'h4000);
      chk("E_last", adr_q[a0+3], 32'h400C);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
